add_sub_serial_param: RTL and testbench
=======================================

Name: add_sub_serial_param

Overview:
Parametrised digit-serial adder/subtractor and the successor to the fixed 8-bit bit-serial adder. It processes DIGIT bits per clock over WIDTH-bit operands and supports add and subtract modes. It provides a start/busy/done handshake and flags carry/borrow and signed overflow. It sits in the datapath-arithmetic group as a low-area alternative to a parallel adder.

Parameters:
WIDTH, 8, operand and result width in bits; must be at least 2.
DIGIT, 1, bits processed per clock; must divide WIDTH evenly (elaboration-time check fails otherwise).
NDIG, WIDTH/DIGIT, derived localparam giving the number of RUN cycles; not user-overridable.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request an operation; sampled only when ready.
mode  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start.
a  input  WIDTH  operand A; captured with start.
b  input  WIDTH  operand B; captured with start.
busy  output  1  high while the FSM is in RUN.
done  output  1  single-cycle pulse; result and flags are valid from this cycle onward.
result  output  WIDTH  sum or difference; holds its value until the next completion.
carry_out  output  1  carry out of the MSB. In subtract mode, 1 = no borrow (a >= b unsigned).
overflow  output  1  two's-complement overflow, defined as carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, any state, including mid-operation): FSM goes to IDLE.
- Reset values: busy=0, done=0, result=0, carry_out=0, overflow=0, all internal shift registers, carry and digit counter = 0.
- An operation in flight is abandoned with no done pulse.
- FSM has three states: IDLE, RUN, DONE. ready = (state==IDLE or state==DONE).
- IDLE: on start=1, capture operands, go to RUN.
  - a_sh <= a.
  - b_sh <= mode ? ~b : b.
  - carry <= mode.
  - cnt <= 0.
- RUN: on each edge, add the low DIGIT bits of a_sh and b_sh with carry in via ripple.
  - Shift a_sh and b_sh right by DIGIT.
  - Shift the sum digit into the MSB end of acc. acc is internal and separate from result.
  - carry <= digit carry out.
  - cnt <= cnt+1.
  - start is ignored.
- RUN, final cycle (cnt==NDIG-1): on that edge, load result from the completed accumulator value, including the final digit.
  - carry_out <= final carry.
  - overflow <= carry-into-MSB XOR final carry. Carry-into-MSB is taken from the final digit's internal ripple.
  - Go to DONE.
- DONE: done=1 for exactly this one cycle.
  - If start=1, a new operation is captured as in IDLE and the FSM goes to RUN (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Latency: the edge that samples start is edge 0. done is high in the cycle following edge NDIG. Throughput is one operation per NDIG+1 cycles.
- busy is a registered output: busy = (state==RUN). done = (state==DONE).
- result, carry_out and overflow change only on the final RUN edge. They are stable during the whole of the next operation until its completion.
- Arithmetic is modulo 2^WIDTH and no bits are lost. cnt width is clog2(NDIG) bits, minimum 1.
- A change to a, b or mode after capture has no effect on the operation in flight.

Decomposition:
- Shared package arith_pkg holds:
  - the FSM state enum (IDLE=0, RUN=1, DONE=2, 2-bit encoding);
  - the mode constants MODE_ADD=0 and MODE_SUB=1;
  - a clog2-based width helper for the counter.
- One natural sub-module, digit_adder (parameter DIGIT), purely combinational:
  - inputs x[DIGIT], y[DIGIT], cin;
  - outputs s[DIGIT], cout, and c_msb_in (carry into its top bit).
- The top module owns the FSM, the shift registers and the output registers.

Test Plan:
- WIDTH=8, DIGIT=1, add 0x3C+0x15 -> done pulses 8 edges after start; result=0x51, carry_out=0, overflow=0; busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=1:
  - add 0x7F+0x01 -> 0x80, ovf=1, cout=0.
  - add 0xFF+0x01 -> 0x00, cout=1, ovf=0.
- WIDTH=8, DIGIT=1, subtract:
  - 0x10-0x20 -> 0xF0, cout=0 (borrow), ovf=0.
  - 0x80-0x01 -> 0x7F, cout=1, ovf=1.
- WIDTH=8, DIGIT=4, add 0x3C+0x15 -> done 2 edges after start, result=0x51.
- WIDTH=16, DIGIT=2, add 0xFFFF+0x0001 -> done after 8 edges, result=0x0000, cout=1.
- Handshake and reset:
  - start held high during RUN is ignored.
  - start asserted in the DONE cycle launches the next operation with no idle cycle.
  - rst pulsed at RUN cycle 3 -> all outputs 0, no done pulse, the next operation completes correctly.

Source files
------------

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and helpers for the digit-serial arithmetic blocks
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Counter width for n states, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational ripple adder for one DIGIT-bit slice
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic rc;

  // Ripple the carry across the slice, remembering the carry entering the top bit
  always_comb begin
    rc       = cin;
    s        = '0;
    c_msb_in = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = rc;
      s[i] = x[i] ^ y[i] ^ rc;
      rc   = (x[i] & y[i]) | (rc & (x[i] ^ y[i]));
    end
    cout = rc;
  end

endmodule

// File: rtl/add_sub_serial_param.sv
// rtl/add_sub_serial_param.sv - digit-serial adder/subtractor with start/busy/done handshake
module add_sub_serial_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  import arith_pkg::*;

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_param_check
    $error("add_sub_serial_param: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout;
  logic             dig_cmsb;
  logic [WIDTH-1:0] sum_ext;
  logic [WIDTH-1:0] acc_next;
  logic             last_digit;
  logic             ready;
  logic             capture;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x        (a_sh_q[DIGIT-1:0]),
    .y        (b_sh_q[DIGIT-1:0]),
    .cin      (carry_q),
    .s        (dig_s),
    .cout     (dig_cout),
    .c_msb_in (dig_cmsb)
  );

  assign last_digit = (cnt_q == CW'(NDIG - 1));
  assign ready      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign capture    = start && ready;

  // New digit enters at the top of the accumulator while earlier digits move down
  always_comb begin
    sum_ext              = '0;
    sum_ext[DIGIT-1:0]   = dig_s;
    acc_next             = (acc_q >> DIGIT) | (sum_ext << (WIDTH - DIGIT));
  end

  // FSM next state: start is only honoured while ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_digit) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: capture operands, shift one digit per RUN cycle, publish on the last
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (capture) begin
      a_sh_d  = a;
      b_sh_d  = (mode == MODE_SUB) ? ~b : b;
      carry_d = (mode == MODE_SUB);
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_sh_d  = a_sh_q >> DIGIT;
      b_sh_d  = b_sh_q >> DIGIT;
      acc_d   = acc_next;
      carry_d = dig_cout;
      cnt_d   = cnt_q + CW'(1);
      if (last_digit) begin
        result_d = acc_next;
        cout_d   = dig_cout;
        ovf_d    = dig_cmsb ^ dig_cout;
      end
    end
  end

  // State register, abandoned immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Shift registers, counter and published outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_add_sub_serial_param.sv
// tb/tb_add_sub_serial_param.sv - randomized self-checking bench for add_sub_serial_param
module tb_add_sub_serial_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        st [3];
  logic        md [3];
  logic [15:0] av [3];
  logic [15:0] bv [3];

  logic       bz0, dn0, co0, ov0;
  logic [7:0] r0;
  logic       bz1, dn1, co1, ov1;
  logic [7:0] r1;
  logic        bz2, dn2, co2, ov2;
  logic [15:0] r2;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prev_r [3];
  logic        prev_c [3];
  logic        prev_v [3];

  always #5 clk = ~clk;

  add_sub_serial_param #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .mode(md[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
    .busy(bz0), .done(dn0), .result(r0), .carry_out(co0), .overflow(ov0)
  );

  add_sub_serial_param #(.WIDTH(8), .DIGIT(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .mode(md[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
    .busy(bz1), .done(dn1), .result(r1), .carry_out(co1), .overflow(ov1)
  );

  add_sub_serial_param #(.WIDTH(16), .DIGIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(st[2]), .mode(md[2]), .a(av[2]), .b(bv[2]),
    .busy(bz2), .done(dn2), .result(r2), .carry_out(co2), .overflow(ov2)
  );

  function automatic int wid(input int k);
    return (k == 2) ? 16 : 8;
  endfunction

  function automatic int ndig(input int k);
    return (k == 1) ? 2 : 8;
  endfunction

  function automatic logic [15:0] res_of(input int k);
    case (k)
      0:       return {8'h00, r0};
      1:       return {8'h00, r1};
      default: return r2;
    endcase
  endfunction

  // {busy, done, carry_out, overflow}
  function automatic logic [3:0] flags_of(input int k);
    case (k)
      0:       return {bz0, dn0, co0, ov0};
      1:       return {bz1, dn1, co1, ov1};
      default: return {bz2, dn2, co2, ov2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic and sign rules
  task automatic model(input int k, input logic m, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic c, output logic v);
    int          w;
    logic [31:0] mask, xx, yy, s;
    logic        sx, sy, sr;
    w    = wid(k);
    mask = (32'd1 << w) - 32'd1;
    xx   = {16'h0, x} & mask;
    yy   = {16'h0, y} & mask;
    if (m) begin
      s = (xx - yy) & mask;
      c = (xx >= yy);
    end else begin
      s = xx + yy;
      c = s[w];
      s = s & mask;
    end
    r  = s[15:0];
    sx = xx[w-1];
    sy = yy[w-1];
    sr = s[w-1];
    v  = m ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
  endtask

  task automatic op(input int k, input logic m, input logic [15:0] x, input logic [15:0] y,
                    input bit hold, input bit chained);
    logic [15:0] er;
    logic        ec, ev;
    logic [3:0]  f;
    int          n, lat, nb;
    model(k, m, x, y, er, ec, ev);
    n = ndig(k);
    if (!chained) @(negedge clk);
    st[k] = 1'b1;
    md[k] = m;
    av[k] = x;
    bv[k] = y;
    @(posedge clk);
    #1;
    if (!hold) st[k] = 1'b0;
    md[k] = 1'($urandom);
    av[k] = 16'($urandom);
    bv[k] = 16'($urandom);
    lat = -1;
    nb  = 0;
    f   = '0;
    for (int i = 0; i < n + 4; i++) begin
      @(negedge clk);
      f = flags_of(k);
      if (i == 0) chk("hold_prev", {14'h0, res_of(k), f[1], f[0]}, {14'h0, prev_r[k], prev_c[k], prev_v[k]});
      if (f[2]) begin
        lat = i;
        break;
      end
      if (f[3]) nb++;
    end
    st[k] = 1'b0;
    chk("latency", lat, n);
    chk("busy_cycles", nb, n);
    chk("result", {16'h0, res_of(k)}, {16'h0, er});
    chk("carry_out", {31'h0, f[1]}, {31'h0, ec});
    chk("overflow", {31'h0, f[0]}, {31'h0, ev});
    prev_r[k] = er;
    prev_c[k] = ec;
    prev_v[k] = ev;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  f;
    int          k, lastk, nd;
    logic        m;
    logic [15:0] x, y;
    bit          hold, chained;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 0; md[i] = 0; av[i] = '0; bv[i] = '0;
      prev_r[i] = '0; prev_c[i] = 0; prev_v[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      f = flags_of(i);
      chk("reset_result", {16'h0, res_of(i)}, 32'h0);
      chk("reset_flags", {28'h0, f}, 32'h0);
    end
    rst = 1'b0;

    op(0, 1'b0, 16'h3C, 16'h15, 0, 0);
    @(negedge clk);
    f = flags_of(0);
    chk("idle_after_done", {30'h0, f[3:2]}, 32'h0);
    op(0, 1'b0, 16'h7F, 16'h01, 0, 0);
    op(0, 1'b0, 16'hFF, 16'h01, 0, 0);
    op(0, 1'b1, 16'h10, 16'h20, 0, 0);
    op(0, 1'b1, 16'h80, 16'h01, 0, 0);
    op(1, 1'b0, 16'h3C, 16'h15, 0, 0);
    op(2, 1'b0, 16'hFFFF, 16'h0001, 0, 0);
    op(0, 1'b0, 16'h21, 16'h42, 1, 0);
    op(0, 1'b1, 16'h05, 16'h09, 0, 0);
    op(0, 1'b0, 16'hA5, 16'h5A, 0, 1);
    op(0, 1'b1, 16'h33, 16'h44, 1, 1);

    @(negedge clk);
    st[0] = 1'b1; md[0] = 1'b0; av[0] = 16'h12; bv[0] = 16'h34;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    f = flags_of(0);
    chk("midrun_rst_result", {16'h0, res_of(0)}, 32'h0);
    chk("midrun_rst_flags", {28'h0, f}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      prev_r[i] = '0; prev_c[i] = 0; prev_v[i] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      f = flags_of(0);
      if (f[2] || f[3]) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    op(0, 1'b0, 16'h3C, 16'h15, 0, 0);

    lastk = 0;
    for (int it = 0; it < 45; it++) begin
      k = int'($urandom_range(2, 0));
      m = 1'($urandom);
      case ($urandom_range(3, 0))
        0:       begin x = 16'hFFFF; y = 16'($urandom); end
        1:       begin x = 16'h8000 >> (16 - wid(k)); y = 16'($urandom_range(1, 0)); end
        default: begin x = 16'($urandom); y = 16'($urandom); end
      endcase
      if (wid(k) == 8) begin
        x = x & 16'h00FF;
        y = y & 16'h00FF;
      end
      hold    = ($urandom_range(3, 0) == 0);
      chained = (k == lastk) && ($urandom_range(1, 0) == 1);
      op(k, m, x, y, hold, chained);
      lastk = k;
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
